// File: rtl/gomoku_pkg.sv
// Shared types and constants for the gomoku win scanner.
package gomoku_pkg;

    localparam int GRID_SIZE = 15;
    localparam int WIN_LEN   = 5;
    localparam int COORD_W   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } scan_state_t;

    // Per-direction (drow, dcol) in 2-bit two's complement, indexed by dir:
    // dir0 (0,+1), dir1 (+1,0), dir2 (+1,+1), dir3 (-1,+1)
    localparam logic [3:0][1:0] DIR_DROW = {2'b11, 2'b01, 2'b01, 2'b00};
    localparam logic [3:0][1:0] DIR_DCOL = {2'b01, 2'b01, 2'b00, 2'b01};

endpackage

// File: rtl/gomoku_dir_stepper.sv
// Combinational target-cell generator: start + k*delta (negated on side 1),
// with an in-range flag for the board bounds.
module gomoku_dir_stepper #(
    parameter int GRID_SIZE = gomoku_pkg::GRID_SIZE,
    parameter int COORD_W   = gomoku_pkg::COORD_W,
    parameter int K_W       = 3
) (
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    input  logic [1:0]         i_dir,
    input  logic               i_side,
    input  logic [K_W-1:0]     i_k,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col,
    output logic               o_in_range
);
    import gomoku_pkg::*;

    // Two bits of headroom so start+k can never wrap into the valid range.
    localparam int TW = ((COORD_W > K_W) ? COORD_W : K_W) + 2;
    localparam logic signed [TW-1:0] LIM = TW'(GRID_SIZE);

    logic [1:0]           w_dr, w_dc;
    logic signed [TW-1:0] w_k, w_kneg, w_off_r, w_off_c, w_tr, w_tc;

    assign w_dr   = DIR_DROW[i_dir];
    assign w_dc   = DIR_DCOL[i_dir];
    assign w_k    = TW'(i_k);
    assign w_kneg = -w_k;

    // Delta components are only 0 or +/-1, so k*delta is a select, not a multiply.
    assign w_off_r = (w_dr == 2'b00) ? '0 : ((w_dr[1] ^ i_side) ? w_kneg : w_k);
    assign w_off_c = (w_dc == 2'b00) ? '0 : ((w_dc[1] ^ i_side) ? w_kneg : w_k);

    assign w_tr = TW'(i_row) + w_off_r;
    assign w_tc = TW'(i_col) + w_off_c;

    assign o_in_range = !w_tr[TW-1] && (w_tr < LIM) && !w_tc[TW-1] && (w_tc < LIM);
    assign o_row      = w_tr[COORD_W-1:0];
    assign o_col      = w_tc[COORD_W-1:0];

endmodule

// File: rtl/gomoku_win_scanner.sv
// Sequential five-in-a-row detector: walks the four line directions outward
// from the placed stone, one board read per req/gnt transfer.
module gomoku_win_scanner #(
    parameter int GRID_SIZE = gomoku_pkg::GRID_SIZE,
    parameter int WIN_LEN   = gomoku_pkg::WIN_LEN,
    parameter int COORD_W   = gomoku_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] start_row,
    input  logic [COORD_W-1:0] start_col,
    input  logic [1:0]         start_player,
    output logic               busy,
    output logic               rd_req,
    input  logic               rd_gnt,
    output logic [COORD_W-1:0] rd_row,
    output logic [COORD_W-1:0] rd_col,
    input  logic [1:0]         rd_data,
    output logic               done,
    output logic               win,
    output logic [1:0]         win_player
);
    import gomoku_pkg::*;

    localparam int CNT_W = $clog2(WIN_LEN + 1);

    scan_state_t          r_state, w_next;
    logic [COORD_W-1:0]   r_row, r_col;
    logic [1:0]           r_player;
    logic [CNT_W-1:0]     r_count, r_k;
    logic [1:0]           r_dir;
    logic                 r_side;
    logic                 r_win;
    logic [1:0]           r_win_player;

    logic [COORD_W-1:0]   w_trow, w_tcol;
    logic                 w_in_range;
    logic                 w_last_side;
    logic                 w_match;
    logic                 w_hit_win;

    gomoku_dir_stepper #(
        .GRID_SIZE (GRID_SIZE),
        .COORD_W   (COORD_W),
        .K_W       (CNT_W)
    ) u_step (
        .i_row      (r_row),
        .i_col      (r_col),
        .i_dir      (r_dir),
        .i_side     (r_side),
        .i_k        (r_k),
        .o_row      (w_trow),
        .o_col      (w_tcol),
        .o_in_range (w_in_range)
    );

    assign w_last_side = r_side && (r_dir == 2'd3);
    assign w_match     = (rd_data == r_player);
    assign w_hit_win   = w_match && (r_count == CNT_W'(WIN_LEN - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: a side ends on an out-of-range target or a non-matching cell.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (start_player == EMPTY) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (!w_in_range)  w_next = w_last_side ? S_DONE : S_ISSUE;
                else if (rd_gnt)  w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_match) w_next = w_hit_win ? S_DONE : S_ISSUE;
                else         w_next = w_last_side ? S_DONE : S_ISSUE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Scan datapath: coordinates, direction/side/k walk, run count and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_player     <= '0;
            r_count      <= '0;
            r_k          <= '0;
            r_dir        <= '0;
            r_side       <= 1'b0;
            r_win        <= 1'b0;
            r_win_player <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_row        <= start_row;
                    r_col        <= start_col;
                    r_player     <= start_player;
                    r_count      <= CNT_W'(1);
                    r_k          <= CNT_W'(1);
                    r_dir        <= '0;
                    r_side       <= 1'b0;
                    r_win        <= 1'b0;
                    r_win_player <= '0;
                end
                S_ISSUE, S_WAIT: begin
                    if (r_state == S_WAIT && w_match) begin
                        r_count <= r_count + CNT_W'(1);
                        r_k     <= r_k + CNT_W'(1);
                        if (w_hit_win) begin
                            r_win        <= 1'b1;
                            r_win_player <= r_player;
                        end
                    end else if (r_state == S_WAIT || !w_in_range) begin
                        // End of side: flip to the mirror side, or advance direction.
                        r_k <= CNT_W'(1);
                        if (!r_side) begin
                            r_side <= 1'b1;
                        end else begin
                            r_side  <= 1'b0;
                            r_dir   <= r_dir + 2'd1;
                            r_count <= CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign rd_req     = (r_state == S_ISSUE) && w_in_range;
    assign rd_row     = rd_req ? w_trow : '0;
    assign rd_col     = rd_req ? w_tcol : '0;
    assign win        = r_win;
    assign win_player = r_win_player;

endmodule

// File: tb/tb_gomoku_win_scanner.sv
// Bench for gomoku_win_scanner: directed scenarios plus randomized boards
// checked against a line-walking reference model.
module tb_gomoku_win_scanner;

    localparam int G = 15;

    logic       clk, rst, start;
    logic [3:0] start_row, start_col;
    logic [1:0] start_player;
    logic       busy, rd_req, rd_gnt;
    logic [3:0] rd_row, rd_col;
    logic [1:0] rd_data;
    logic       done, win;
    logic [1:0] win_player;

    logic [1:0] board [0:G-1][0:G-1];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    gomoku_win_scanner dut (
        .clk(clk), .rst(rst), .start(start), .start_row(start_row),
        .start_col(start_col), .start_player(start_player), .busy(busy),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .done(done), .win(win), .win_player(win_player)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Board read port: capture granted address, return cell the next cycle.
    always @(posedge clk) begin
        if (rd_req && rd_gnt) begin
            got_q.push_back({rd_row, rd_col});
            chk("rd_addr_in_range", 32'((rd_row < 4'd15) && (rd_col < 4'd15)), 32'd1);
            rd_data <= board[rd_row][rd_col];
        end
    end

    // Reference: walk each line from the rules; record reads and cycle cost.
    function automatic void ref_scan(input int r, input int c, input int p,
                                     output bit w, output int cyc);
        int dr[4] = '{0, 1, 1, -1};
        int dc[4] = '{1, 0, 1, 1};
        exp_q.delete();
        w = 1'b0;
        cyc = 0;
        if (p == 0) return;
        for (int d = 0; d < 4; d++) begin
            int cnt = 1;
            for (int s = 0; s < 2; s++) begin
                int sg = (s == 0) ? 1 : -1;
                for (int k = 1; k < 5; k++) begin
                    int tr = r + sg * k * dr[d];
                    int tc = c + sg * k * dc[d];
                    if (tr < 0 || tr >= G || tc < 0 || tc >= G) begin
                        cyc += 1;
                        break;
                    end
                    exp_q.push_back(8'(tr * 16 + tc));
                    cyc += 2;
                    if (int'(board[tr][tc]) == p) begin
                        cnt++;
                        if (cnt >= 5) begin
                            w = 1'b1;
                            return;
                        end
                    end else begin
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic clear_board();
        for (int i = 0; i < G; i++)
            for (int j = 0; j < G; j++)
                board[i][j] = 2'd0;
    endtask

    // One scan: start at cycle 0, optional initial grant stall, optional
    // start pulse while busy, optional random grant. Returns done cycle.
    task automatic run_scan(input string tag, input int r, input int c, input int p,
                            input int stall, input bit rnd_gnt, input int poke_cyc,
                            output int done_cyc);
        bit ew;
        int ecyc;
        int cyc;
        logic [7:0] hold;
        ref_scan(r, c, p, ew, ecyc);
        got_q.delete();
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        start = 1'b1; start_row = 4'(r); start_col = 4'(c); start_player = 2'(p);
        rd_gnt = (stall > 0) ? 1'b0 : 1'b1;
        cyc = 0;
        done_cyc = -1;
        hold = '0;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == poke_cyc) begin
                start = 1'b1; start_row = 4'd0; start_col = 4'd0; start_player = 2'd2;
            end else begin
                start = 1'b0;
            end
            if (rnd_gnt)        rd_gnt = 1'($urandom_range(0, 1));
            else if (stall > 0) rd_gnt = (cyc > stall);
            if (stall > 0 && cyc == 1) hold = {rd_row, rd_col};
            if (stall > 0 && cyc >= 2 && cyc <= stall + 1) begin
                chk({tag, "_stall_addr"}, 32'({rd_row, rd_col}), 32'(hold));
                chk({tag, "_stall_req"}, 32'(rd_req), 32'd1);
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        rd_gnt = 1'b1;
        start = 1'b0;
        chk({tag, "_timeout"}, 32'(done_cyc > 0), 32'd1);
        chk({tag, "_win"}, 32'(win), 32'(ew));
        chk({tag, "_win_player"}, 32'(win_player), ew ? 32'(p) : 32'd0);
        if (!rnd_gnt) chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(ecyc + stall + 1));
        chk({tag, "_nreads"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_read_addr"}, 32'(got_q[i]), 32'(exp_q[i]));
        // start in the DONE cycle is dropped; result is held afterwards
        start = 1'b1; start_row = 4'd7; start_col = 4'd7; start_player = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_after_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_after_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_win_held"}, 32'(win), 32'(ew));
    endtask

    initial begin
        int dc_;
        int ndone;
        clear_board();
        rst = 1'b1; start = 1'b0; start_row = '0; start_col = '0; start_player = '0;
        rd_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(rd_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_wp", 32'(win_player), 32'd0);
        chk("rst_addr", 32'({rd_row, rd_col}), 32'd0);
        rst = 1'b0;

        // Empty board, centre
        run_scan("empty_centre", 7, 7, 1, 0, 1'b0, 0, dc_);
        chk("empty_centre_cycle17", 32'(dc_), 32'd17);
        chk("empty_centre_8reads", 32'(got_q.size()), 32'd8);

        // Empty board, corner: only (0,1), (1,0), (1,1)
        run_scan("corner", 0, 0, 1, 0, 1'b0, 0, dc_);
        chk("corner_cycle12", 32'(dc_), 32'd12);
        chk("corner_3reads", 32'(got_q.size()), 32'd3);
        chk("corner_r0", 32'(got_q[0]), 32'h01);
        chk("corner_r1", 32'(got_q[1]), 32'h10);
        chk("corner_r2", 32'(got_q[2]), 32'h11);

        // Player 0: straight to DONE
        run_scan("p0", 5, 5, 0, 0, 1'b0, 0, dc_);
        chk("p0_cycle1", 32'(dc_), 32'd1);

        // Row win found on side 1
        clear_board();
        for (int j = 3; j <= 7; j++) board[7][j] = 2'd1;
        run_scan("row_win", 7, 7, 1, 0, 1'b0, 0, dc_);
        chk("row_win_cycle11", 32'(dc_), 32'd11);
        chk("row_win_flag", 32'(win), 32'd1);
        chk("row_win_5reads", 32'(got_q.size()), 32'd5);

        // Anti-diagonal P2 win, then broken by a P1 stone
        clear_board();
        board[11][3] = 2'd2; board[10][4] = 2'd2; board[8][6] = 2'd2;
        board[7][7] = 2'd2;  board[9][5] = 2'd2;
        run_scan("anti_diag", 9, 5, 2, 0, 1'b0, 0, dc_);
        chk("anti_diag_wp2", 32'(win_player), 32'd2);
        board[10][4] = 2'd1;
        run_scan("anti_diag_broken", 9, 5, 2, 0, 1'b0, 0, dc_);
        chk("anti_diag_broken_win0", 32'(win), 32'd0);

        // Overline of six counts as a win
        clear_board();
        for (int i = 2; i <= 7; i++) board[i][i] = 2'd1;
        run_scan("overline", 4, 4, 1, 0, 1'b0, 0, dc_);
        chk("overline_win", 32'(win), 32'd1);

        // Grant stall of 5 cycles on the first read, with a start poked while busy
        clear_board();
        run_scan("stall", 7, 7, 1, 5, 1'b0, 3, dc_);
        chk("stall_cycle22", 32'(dc_), 32'd22);

        // Reset mid-scan at cycle 6
        @(posedge clk); #1;
        start = 1'b1; start_row = 4'd7; start_col = 4'd7; start_player = 2'd1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(rd_req), 32'd0);
        chk("midrst_win", 32'(win), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        run_scan("after_rst", 7, 7, 1, 0, 1'b0, 0, dc_);

        // Randomized boards, some with a planted line; odd runs use random grant
        for (int it = 0; it < 40; it++) begin
            int r, c, p, d, o;
            int dr[4] = '{0, 1, 1, -1};
            int dcl[4] = '{1, 0, 1, 1};
            for (int i = 0; i < G; i++)
                for (int j = 0; j < G; j++) begin
                    int v = $urandom_range(0, 9);
                    board[i][j] = (v < 3) ? 2'd1 : (v < 6) ? 2'd2 : 2'd0;
                end
            r = $urandom_range(0, G - 1);
            c = $urandom_range(0, G - 1);
            p = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom_range(0, 3);
                o = $urandom_range(0, 4);
                for (int i = 0; i < 5; i++) begin
                    int tr = r + (i - o) * dr[d];
                    int tc = c + (i - o) * dcl[d];
                    if (tr >= 0 && tr < G && tc >= 0 && tc < G) board[tr][tc] = 2'(p);
                end
            end
            board[r][c] = 2'(p);
            run_scan("rand", r, c, p, 0, 1'((it % 2) == 1), 0, dc_);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
